button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/btn_pkg.sv | 28 ++
 rtl/btn_channel.sv | 136 +++++++++++++
 rtl/button_conditioner.sv | 38 +++
 tb/tb_button_conditioner.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and constants for the button conditioner: channel FSM states,
// pad index assignment and default timing at the 33 MHz pixel clock.
package btn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_DEB_PRESS   = 3'd1,
        ST_HELD_DELAY  = 3'd2,
        ST_HELD_REPEAT = 3'd3,
        ST_DEB_RELEASE = 3'd4
    } btn_state_e;

    localparam int BTN_LEFT  = 0;
    localparam int BTN_RIGHT = 1;
    localparam int BTN_UP    = 2;
    localparam int BTN_DOWN  = 3;

    localparam int DEF_DEB_CYC    = 330000;    // 10 ms
    localparam int DEF_REP_DELAY  = 13200000;  // 400 ms
    localparam int DEF_REP_PERIOD = 3300000;   // 100 ms

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchronizer, debounce/auto-repeat FSM, shared counter.
// Outputs are registered; pad edge to accepted press/release is 2 + DEB_CYC cycles.
module btn_channel
    import btn_pkg::*;
#(
    parameter int ACTIVE_LOW = 1,
    parameter int DEB_CYC    = DEF_DEB_CYC,
    parameter int REP_DELAY  = DEF_REP_DELAY,
    parameter int REP_PERIOD = DEF_REP_PERIOD,
    parameter int REP_EN     = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pad,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam int CNT_W = $clog2(max3(DEB_CYC, REP_DELAY, REP_PERIOD) + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    // The first pressed/released read happens in the previous state, so the
    // debounce state only needs DEB_CYC-1 more reads (count values 0..DEB_CYC-2).
    localparam logic [CNT_W-1:0] DEB_TH = CNT_W'((DEB_CYC >= 2) ? DEB_CYC - 2 : 0);
    localparam logic [CNT_W-1:0] REP_DELAY_TH  = CNT_W'((REP_DELAY >= 1) ? REP_DELAY - 1 : 0);
    localparam logic [CNT_W-1:0] REP_PERIOD_TH = CNT_W'((REP_PERIOD >= 1) ? REP_PERIOD - 1 : 0);
    localparam logic REL_LVL  = (ACTIVE_LOW != 0);
    localparam bit   FAST_DEB = (DEB_CYC <= 1);
    localparam bit   REP_ON   = (REP_EN != 0);

    logic [1:0]       sync_q, sync_d;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             from_rep_q, from_rep_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             pressed;

    always_comb begin
        sync_d  = {sync_q[0], i_pad};
        pressed = sync_q[1] ^ REL_LVL;
    end

    always_comb begin
        state_d    = state_q;
        from_rep_d = from_rep_q;
        level_d    = level_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        cnt_d      = cnt_inc;

        case (state_q)
            ST_IDLE: begin
                if (pressed) begin
                    if (FAST_DEB) begin
                        state_d = ST_HELD_DELAY;
                        level_d = 1'b1;
                        press_d = 1'b1;
                    end else begin
                        state_d = ST_DEB_PRESS;
                    end
                end
            end
            ST_DEB_PRESS: begin
                if (!pressed) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == DEB_TH) begin
                    state_d = ST_HELD_DELAY;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end
            end
            ST_HELD_DELAY, ST_HELD_REPEAT: begin
                if (!pressed) begin
                    from_rep_d = (state_q == ST_HELD_REPEAT);
                    if (FAST_DEB) begin
                        state_d   = ST_IDLE;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                    end else begin
                        state_d = ST_DEB_RELEASE;
                    end
                end else if (REP_ON && state_q == ST_HELD_DELAY && cnt_q == REP_DELAY_TH) begin
                    state_d = ST_HELD_REPEAT;
                    press_d = 1'b1;
                end else if (state_q == ST_HELD_REPEAT && cnt_q == REP_PERIOD_TH) begin
                    press_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            ST_DEB_RELEASE: begin
                if (pressed) begin
                    state_d = from_rep_q ? ST_HELD_REPEAT : ST_HELD_DELAY;
                end else if (cnt_q == DEB_TH) begin
                    state_d   = ST_IDLE;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A bounce back into HELD_* restarts repeat timing from zero.
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q     <= {2{REL_LVL}};
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            from_rep_q <= 1'b0;
            level_q    <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            from_rep_q <= from_rep_d;
            level_q    <= level_d;
            press_q    <= press_d;
            release_q  <= release_d;
        end
    end

    assign o_level   = level_q;
    assign o_press   = press_q;
    assign o_release = release_q;

endmodule

// File: rtl/button_conditioner.sv
// Debounce and auto-repeat for N_BTN raw pads feeding the square-drawing direction inputs.
// Channels are fully independent; simultaneous presses give simultaneous pulses.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN      = 4,
    parameter int ACTIVE_LOW = 1,
    parameter int DEB_CYC    = DEF_DEB_CYC,
    parameter int REP_DELAY  = DEF_REP_DELAY,
    parameter int REP_PERIOD = DEF_REP_PERIOD,
    parameter int REP_EN     = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_BTN-1:0] i_btn,
    output logic [N_BTN-1:0] o_level,
    output logic [N_BTN-1:0] o_press,
    output logic [N_BTN-1:0] o_release
);

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        btn_channel #(
            .ACTIVE_LOW (ACTIVE_LOW),
            .DEB_CYC    (DEB_CYC),
            .REP_DELAY  (REP_DELAY),
            .REP_PERIOD (REP_PERIOD),
            .REP_EN     (REP_EN)
        ) u_ch (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_pad     (i_btn[g]),
            .o_level   (o_level[g]),
            .o_press   (o_press[g]),
            .o_release (o_release[g])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random pad activity,
// both compared against a run-length reference model (repeat on and off).
module tb_button_conditioner;
    import btn_pkg::*;

    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RP  = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn;
    logic [3:0] lv_a, pr_a, rl_a, lv_b, pr_b, rl_b;

    always #5 clk = ~clk;

    button_conditioner #(
        .N_BTN(4), .ACTIVE_LOW(1), .DEB_CYC(DEB), .REP_DELAY(RD), .REP_PERIOD(RP), .REP_EN(1)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_btn(btn),
        .o_level(lv_a), .o_press(pr_a), .o_release(rl_a)
    );

    button_conditioner #(
        .N_BTN(4), .ACTIVE_LOW(1), .DEB_CYC(DEB), .REP_DELAY(RD), .REP_PERIOD(RP), .REP_EN(0)
    ) dut_nr (
        .i_clk(clk), .i_rst(rst), .i_btn(btn),
        .o_level(lv_b), .o_press(pr_b), .o_release(rl_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pressed reads arrive two cycles late; a level change is
    // accepted after DEB consecutive reads disagreeing with the current level;
    // repeats fire after RD (first) / RP (later) counted held reads, where a
    // released read stops counting and the pressed read that ends it restarts it.
    bit         s1 [4];
    bit         s2 [4];
    int         mis [2][4];
    int         rc  [2][4];
    bit         lv  [2][4];
    bit         ph  [2][4];
    bit         bn  [2][4];
    logic [3:0] e_lv [2];
    logic [3:0] e_pr [2];
    logic [3:0] e_rl [2];

    always @(posedge clk or posedge rst) begin : mdl
        bit s;
        bit pr, rl;
        if (rst) begin
            for (int c = 0; c < 4; c++) begin
                s1[c] = 1'b0;
                s2[c] = 1'b0;
            end
            for (int m = 0; m < 2; m++) begin
                e_lv[m] = '0; e_pr[m] = '0; e_rl[m] = '0;
                for (int c = 0; c < 4; c++) begin
                    mis[m][c] = 0; rc[m][c] = 0;
                    lv[m][c] = 0; ph[m][c] = 0; bn[m][c] = 0;
                end
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                for (int c = 0; c < 4; c++) begin
                    s  = s2[c];
                    pr = 1'b0;
                    rl = 1'b0;
                    if (s != lv[m][c]) mis[m][c]++;
                    else               mis[m][c] = 0;
                    if (mis[m][c] == DEB) begin
                        lv[m][c]  = s;
                        mis[m][c] = 0;
                        if (s) begin
                            pr = 1'b1;
                            rc[m][c] = 0; ph[m][c] = 0; bn[m][c] = 0;
                        end else begin
                            rl = 1'b1;
                        end
                    end else if (lv[m][c] && s) begin
                        if (bn[m][c]) begin
                            bn[m][c] = 0;
                            rc[m][c] = 0;
                        end else begin
                            rc[m][c]++;
                            if (m == 0 && rc[m][c] == (ph[m][c] ? RP : RD)) begin
                                pr = 1'b1;
                                rc[m][c] = 0;
                                ph[m][c] = 1;
                            end
                        end
                    end else if (lv[m][c] && !s) begin
                        bn[m][c] = 1;
                    end
                    e_lv[m][c] = lv[m][c];
                    e_pr[m][c] = pr;
                    e_rl[m][c] = rl;
                end
            end
            for (int c = 0; c < 4; c++) begin
                s2[c] = s1[c];
                s1[c] = ~btn[c];
            end
        end
    end

    always @(negedge clk) begin
        check_eq("mdl_lvl_a", lv_a, e_lv[0]);
        check_eq("mdl_prs_a", pr_a, e_pr[0]);
        check_eq("mdl_rel_a", rl_a, e_rl[0]);
        check_eq("mdl_lvl_b", lv_b, e_lv[1]);
        check_eq("mdl_prs_b", pr_b, e_pr[1]);
        check_eq("mdl_rel_b", rl_b, e_rl[1]);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    function automatic logic [3:0] any_out();
        return lv_a | pr_a | rl_a | lv_b | pr_b | rl_b;
    endfunction

    logic [3:0] acc;
    int         na, nb;
    int         tmr [4];

    initial begin
        btn = 4'hF;
        rst = 1'b0;
        #1 rst = 1'b1;
        tick(3);
        check_eq("rst_lvl", lv_a, 0);
        check_eq("rst_prs", pr_a, 0);
        check_eq("rst_rel", rl_a, 0);
        check_eq("rst_any_b", lv_b | pr_b | rl_b, 0);

        rst = 1'b0;
        acc = '0;
        repeat (100) begin
            tick(1);
            acc |= any_out();
        end
        check_eq("idle_100", acc, 0);

        // hold left: accept at 6, repeats at 16, 21, 26
        btn[BTN_LEFT] = 1'b0;
        tick(5);
        check_eq("l_c5_prs", pr_a[0], 0);
        check_eq("l_c5_lvl", lv_a[0], 0);
        tick(1);
        check_eq("l_c6_lvl", lv_a[0], 1);
        check_eq("l_c6_prs", pr_a[0], 1);
        tick(1);
        check_eq("l_c7_prs", pr_a[0], 0);
        tick(9);
        check_eq("l_rep16", pr_a[0], 1);
        check_eq("l_norep16_b", pr_b[0], 0);
        tick(5);
        check_eq("l_rep21", pr_a[0], 1);
        tick(5);
        check_eq("l_rep26", pr_a[0], 1);
        btn[BTN_LEFT] = 1'b1;
        tick(5);
        check_eq("l_rel_c5", rl_a[0], 0);
        check_eq("l_norep_deb", pr_a[0], 0);
        tick(1);
        check_eq("l_rel_c6", rl_a[0], 1);
        check_eq("l_rel_lvl", lv_a[0], 0);
        tick(10);

        // 3-cycle glitch on up
        acc = '0;
        btn[BTN_UP] = 1'b0;
        repeat (3) begin tick(1); acc |= any_out(); end
        btn[BTN_UP] = 1'b1;
        repeat (10) begin tick(1); acc |= any_out(); end
        check_eq("glitch", acc, 0);

        // left + right together
        btn[1:0] = 2'b00;
        tick(6);
        check_eq("sim_prs_a", pr_a[1:0], 2'b11);
        check_eq("sim_prs_b", pr_b[1:0], 2'b11);
        tick(3);
        btn[1:0] = 2'b11;
        tick(5);
        check_eq("sim_rel_c5", rl_a[1:0], 0);
        tick(1);
        check_eq("sim_rel_a", rl_a[1:0], 2'b11);
        check_eq("sim_rel_b", rl_b[1:0], 2'b11);
        check_eq("sim_rel_noprs", pr_a[1:0], 0);
        tick(10);

        // hold right 100 cycles: 18 pulses with repeat, 1 without
        na = 0;
        nb = 0;
        btn[BTN_RIGHT] = 1'b0;
        repeat (100) begin
            tick(1);
            na += int'(pr_a[1]);
            nb += int'(pr_b[1]);
        end
        check_eq("hold_cnt_rep", na, 18);
        check_eq("hold_cnt_norep", nb, 1);
        btn[BTN_RIGHT] = 1'b1;
        tick(10);

        // reset in the middle of down repeating
        btn[BTN_DOWN] = 1'b0;
        tick(20);
        rst = 1'b1;
        tick(2);
        check_eq("rst_mid_out", any_out(), 0);
        rst = 1'b0;
        tick(5);
        check_eq("rst_rel_c5", pr_a[3], 0);
        tick(1);
        check_eq("rst_rel_c6_prs", pr_a[3], 1);
        check_eq("rst_rel_c6_lvl", lv_a[3], 1);
        check_eq("rst_rel_c6_b", pr_b[3], 1);
        btn[BTN_DOWN] = 1'b1;
        tick(10);

        // random pad activity: glitches, long holds, bounces, rare resets
        for (int c = 0; c < 4; c++) tmr[c] = $urandom_range(0, 10);
        repeat (4000) begin
            for (int c = 0; c < 4; c++) begin
                if (tmr[c] == 0) begin
                    btn[c] = ~btn[c];
                    if ($urandom_range(0, 2) == 0) tmr[c] = $urandom_range(DEB + 1, 60);
                    else                           tmr[c] = $urandom_range(1, DEB + 2);
                end else begin
                    tmr[c]--;
                end
            end
            rst = ($urandom_range(0, 799) == 0);
            tick(1);
        end
        rst = 1'b0;
        btn = 4'hF;
        tick(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
